// File: rtl/sim_sequencer.sv
// Configure-and-run sequencer for an agent array: it streams the seed, initial state and
// connectivity words to the agents, then emits one infected-count statistic per step.
module sim_sequencer #(
    parameter int NUM_AGENTS = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           run_steps,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [31:0]           cfg_data,
    output logic [31:0]           address,
    output logic [31:0]           seed_value,
    output logic                  load_seed,
    output logic                  init_state,
    output logic                  load_state,
    output logic [NUM_AGENTS-1:0] load_conn,
    output logic [31:0]           conn_value,
    input  logic [NUM_AGENTS-1:0] agent_state,
    output logic                  stat_valid,
    output logic [31:0]           stat_step,
    output logic [15:0]           stat_count,
    output logic                  busy,
    output logic                  done
);

    localparam int WORDS = (NUM_AGENTS + 31) / 32;
    localparam logic [15:0] LAST_AGENT = 16'(NUM_AGENTS - 1);
    localparam logic [15:0] LAST_WORD  = 16'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STATE,
        CONN,
        RUN,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [15:0]           agent_q, agent_d;
    logic [15:0]           word_q, word_d;
    logic [31:0]           step_q, step_d;
    logic [31:0]           run_steps_q, run_steps_d;
    logic [31:0]           address_q, address_d;
    logic [31:0]           seed_value_q, seed_value_d;
    logic                  load_seed_q, load_seed_d;
    logic                  init_state_q, init_state_d;
    logic                  load_state_q, load_state_d;
    logic [NUM_AGENTS-1:0] load_conn_q, load_conn_d;
    logic [31:0]           conn_value_q, conn_value_d;
    logic                  stat_valid_q, stat_valid_d;
    logic [31:0]           stat_step_q, stat_step_d;
    logic [15:0]           stat_count_q, stat_count_d;
    logic                  done_q, done_d;

    logic                  cfg_accept;
    logic [15:0]           pop_cnt;
    logic [NUM_AGENTS-1:0] conn_hit;

    assign cfg_ready  = (state_q == SEED) || (state_q == STATE) || (state_q == CONN);
    assign cfg_accept = cfg_valid && cfg_ready;

    // One-hot decode of the agent currently receiving connectivity words.
    for (genvar gi = 0; gi < NUM_AGENTS; gi++) begin : g_conn_hit
        assign conn_hit[gi] = (agent_q == 16'(gi));
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            pop_cnt = pop_cnt + 16'(agent_state[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        agent_d      = agent_q;
        word_d       = word_q;
        step_d       = step_q;
        run_steps_d  = run_steps_q;
        address_d    = address_q;
        seed_value_d = seed_value_q;
        init_state_d = init_state_q;
        conn_value_d = conn_value_q;
        stat_step_d  = stat_step_q;
        stat_count_d = stat_count_q;
        load_seed_d  = 1'b0;
        load_state_d = 1'b0;
        load_conn_d  = '0;
        stat_valid_d = 1'b0;
        done_d       = (state_q == FIN);

        case (state_q)
            IDLE: begin
                if (start) begin
                    run_steps_d = run_steps;
                    agent_d     = '0;
                    word_d      = '0;
                    step_d      = '0;
                    state_d     = SEED;
                end
            end
            SEED: begin
                if (cfg_accept) begin
                    load_seed_d  = 1'b1;
                    seed_value_d = cfg_data;
                    address_d    = {16'd0, agent_q};
                    if (agent_q == LAST_AGENT) begin
                        agent_d = '0;
                        state_d = STATE;
                    end else begin
                        agent_d = agent_q + 16'd1;
                    end
                end
            end
            STATE: begin
                if (cfg_accept) begin
                    load_state_d = 1'b1;
                    init_state_d = cfg_data[0];
                    address_d    = {16'd0, agent_q};
                    if (agent_q == LAST_AGENT) begin
                        agent_d = '0;
                        state_d = CONN;
                    end else begin
                        agent_d = agent_q + 16'd1;
                    end
                end
            end
            CONN: begin
                if (cfg_accept) begin
                    load_conn_d  = conn_hit;
                    conn_value_d = cfg_data;
                    address_d    = {16'd0, agent_q};
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (agent_q == LAST_AGENT) begin
                            agent_d = '0;
                            step_d  = '0;
                            state_d = (run_steps_q == 32'd0) ? FIN : RUN;
                        end else begin
                            agent_d = agent_q + 16'd1;
                        end
                    end else begin
                        word_d = word_q + 16'd1;
                    end
                end
            end
            RUN: begin
                stat_valid_d = 1'b1;
                stat_count_d = pop_cnt;
                stat_step_d  = step_q;
                step_d       = step_q + 32'd1;
                // run_steps_q is nonzero here: a zero count bypasses RUN entirely.
                if (step_q == run_steps_q - 32'd1) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            agent_q      <= '0;
            word_q       <= '0;
            step_q       <= '0;
            run_steps_q  <= '0;
            address_q    <= '0;
            seed_value_q <= '0;
            load_seed_q  <= 1'b0;
            init_state_q <= 1'b0;
            load_state_q <= 1'b0;
            load_conn_q  <= '0;
            conn_value_q <= '0;
            stat_valid_q <= 1'b0;
            stat_step_q  <= '0;
            stat_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            agent_q      <= agent_d;
            word_q       <= word_d;
            step_q       <= step_d;
            run_steps_q  <= run_steps_d;
            address_q    <= address_d;
            seed_value_q <= seed_value_d;
            load_seed_q  <= load_seed_d;
            init_state_q <= init_state_d;
            load_state_q <= load_state_d;
            load_conn_q  <= load_conn_d;
            conn_value_q <= conn_value_d;
            stat_valid_q <= stat_valid_d;
            stat_step_q  <= stat_step_d;
            stat_count_q <= stat_count_d;
            done_q       <= done_d;
        end
    end

    assign address    = address_q;
    assign seed_value = seed_value_q;
    assign load_seed  = load_seed_q;
    assign init_state = init_state_q;
    assign load_state = load_state_q;
    assign load_conn  = load_conn_q;
    assign conn_value = conn_value_q;
    assign stat_valid = stat_valid_q;
    assign stat_step  = stat_step_q;
    assign stat_count = stat_count_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_sim_sequencer.sv
// Bench for sim_sequencer with four agents: a word-count based model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sim_sequencer;

    localparam int NA = 4;
    localparam int W  = (NA + 31) / 32;
    localparam int T  = NA * (2 + W);

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   run_steps;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [31:0]   cfg_data;
    logic [31:0]   address;
    logic [31:0]   seed_value;
    logic          load_seed;
    logic          init_state;
    logic          load_state;
    logic [NA-1:0] load_conn;
    logic [31:0]   conn_value;
    logic [NA-1:0] agent_state;
    logic          stat_valid;
    logic [31:0]   stat_step;
    logic [15:0]   stat_count;
    logic          busy;
    logic          done;

    sim_sequencer #(.NUM_AGENTS(NA)) dut (
        .clk(clk), .rst(rst), .start(start), .run_steps(run_steps),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .address(address), .seed_value(seed_value), .load_seed(load_seed),
        .init_state(init_state), .load_state(load_state), .load_conn(load_conn),
        .conn_value(conn_value), .agent_state(agent_state), .stat_valid(stat_valid),
        .stat_step(stat_step), .stat_count(stat_count), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 configuring, 2 running, 3 finishing; phase and target agent follow
    // from how many words have been accepted since start.
    int          m_mode = 0, m_n = 0, m_k = 0;
    logic [31:0] m_rs = '0;
    logic [31:0] e_addr = '0, e_seed = '0, e_conn = '0, e_step = '0;
    logic [15:0] e_cnt = '0;
    logic        e_init = 0, e_ls = 0, e_lst = 0, e_sv = 0, e_done = 0, e_ready = 0, e_busy = 0;
    logic [NA-1:0] e_lc = '0;
    bit          model_live = 0;

    always @(posedge clk) begin : model
        int mode, n, k, j, ag;
        logic [31:0] rs, addr, seed, conn, sstep;
        logic [15:0] scnt;
        logic init, ls, lst, sv, dn;
        logic [NA-1:0] lc;
        mode = m_mode; n = m_n; k = m_k; rs = m_rs;
        addr = e_addr; seed = e_seed; conn = e_conn; sstep = e_step; scnt = e_cnt; init = e_init;
        ls = 0; lst = 0; sv = 0; lc = '0; dn = (m_mode == 3);
        if (rst) begin
            mode = 0; n = 0; k = 0; rs = 0;
            addr = 0; seed = 0; conn = 0; sstep = 0; scnt = 0; init = 0; dn = 0;
        end else begin
            case (mode)
                0: if (start) begin
                    mode = 1; n = 0; k = 0; rs = run_steps;
                end
                1: if (cfg_valid) begin
                    if (n < NA) begin
                        ls = 1; addr = n; seed = cfg_data;
                    end else if (n < 2 * NA) begin
                        lst = 1; addr = n - NA; init = cfg_data[0];
                    end else begin
                        j = n - 2 * NA; ag = j / W;
                        lc[ag] = 1'b1; conn = cfg_data; addr = ag;
                    end
                    n++;
                    if (n == T) mode = (rs == 0) ? 3 : 2;
                end
                2: begin
                    sv = 1; scnt = 16'($countones(agent_state)); sstep = k;
                    k++;
                    if (k == int'(rs)) mode = 3;
                end
                default: mode = 0;
            endcase
        end
        m_mode <= mode; m_n <= n; m_k <= k; m_rs <= rs;
        e_addr <= addr; e_seed <= seed; e_conn <= conn; e_step <= sstep; e_cnt <= scnt;
        e_init <= init; e_ls <= ls; e_lst <= lst; e_sv <= sv; e_lc <= lc; e_done <= dn;
        e_ready <= (mode == 1); e_busy <= (mode != 0);
        model_live <= 1;
    end

    logic [31:0] seed_log[$], seed_addr_log[$], conn_log[$], cnt_log[$], step_log[$];
    int          seed_cyc[$], conn_cyc[$];
    int          done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (model_live) begin
            cyc++;
            chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("load_seed", 32'(load_seed), 32'(e_ls));
            chk("load_state", 32'(load_state), 32'(e_lst));
            chk("load_conn", 32'(load_conn), 32'(e_lc));
            chk("address", address, e_addr);
            chk("seed_value", seed_value, e_seed);
            chk("init_state", 32'(init_state), 32'(e_init));
            chk("conn_value", conn_value, e_conn);
            chk("stat_valid", 32'(stat_valid), 32'(e_sv));
            chk("stat_step", stat_step, e_step);
            chk("stat_count", 32'(stat_count), 32'(e_cnt));
            if (load_seed) begin
                seed_log.push_back(seed_value); seed_addr_log.push_back(address);
                seed_cyc.push_back(cyc);
                $display("txn cyc=%0d seed addr=%0d value=0x%0h", cyc, address, seed_value);
            end
            if (load_state)
                $display("txn cyc=%0d state addr=%0d init=%0b", cyc, address, init_state);
            if (load_conn != '0) begin
                conn_log.push_back(32'(load_conn)); conn_cyc.push_back(cyc);
                $display("txn cyc=%0d conn onehot=%b value=0x%0h", cyc, load_conn, conn_value);
            end
            if (stat_valid) begin
                cnt_log.push_back(32'(stat_count)); step_log.push_back(stat_step);
                $display("txn cyc=%0d stat step=%0d count=%0d", cyc, stat_step, stat_count);
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                $display("txn cyc=%0d done", cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        seed_log.delete(); seed_addr_log.delete(); conn_log.delete();
        cnt_log.delete(); step_log.delete(); seed_cyc.delete(); conn_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] steps);
        start = 1; run_steps = steps;
        tick();
        start = 0; run_steps = 32'hDEAD_BEEF;
    endtask

    task automatic send(input logic [31:0] d);
        cfg_valid = 1; cfg_data = d;
        tick();
        cfg_valid = 0; cfg_data = 32'h5A5A_5A5A;
    endtask

    task automatic full_cfg(input logic [31:0] base);
        for (int i = 0; i < T; i++) send(base + 32'(i));
    endtask

    task automatic chk_list(input string name, input logic [31:0] got[$], input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    endtask

    initial begin
        rst = 1; start = 0; run_steps = 0; cfg_valid = 0; cfg_data = 0; agent_state = '0;
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(cfg_ready), 32'd0);
        rst = 0;
        tick();

        // Seeds back-to-back, state/conn with gaps, two run steps.
        clear_logs();
        do_start(2);
        send(32'h11); send(32'h12); send(32'h13); send(32'h14);
        tick();
        send(32'h1); tick(); send(32'hFFFF_FFFE); tick(); send(32'h0); send(32'h0);
        send(32'h2); tick(); send(32'h5); tick(); send(32'hA); tick(); send(32'h4);
        agent_state = 4'b1011; tick();
        agent_state = 4'b0001; tick();
        agent_state = 4'b1111; tick(); tick(); tick();
        chk_list("seed_values", seed_log, '{32'h11, 32'h12, 32'h13, 32'h14});
        chk_list("seed_addrs", seed_addr_log, '{32'd0, 32'd1, 32'd2, 32'd3});
        for (int i = 1; i < seed_cyc.size(); i++)
            chk("seed_consecutive", 32'(seed_cyc[i] - seed_cyc[0]), 32'(i));
        chk_list("conn_onehot", conn_log, '{32'h1, 32'h2, 32'h4, 32'h8});
        chk_list("stat_counts", cnt_log, '{32'd3, 32'd1});
        chk_list("stat_steps", step_log, '{32'd0, 32'd1});
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Zero steps; cfg_valid while idle must not be taken.
        clear_logs();
        cfg_valid = 1; cfg_data = 32'h77; tick();
        do_start(0);
        full_cfg(32'h100);
        tick(); tick(); tick();
        chk("zero_stats", 32'(cnt_log.size()), 32'd0);
        chk("zero_done", 32'(done_cnt), 32'd1);
        chk("zero_seed0", (seed_log.size() > 0) ? seed_log[0] : 32'hX, 32'h100);
        chk("zero_done_after_conn", 32'(done_cyc - conn_cyc[conn_cyc.size()-1]), 32'd1);

        // Reset in the middle of the connectivity phase, then a fresh run.
        clear_logs();
        do_start(3);
        for (int i = 0; i < 2 * NA + 2; i++) send(32'h200 + 32'(i));
        rst = 1; tick(); rst = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conn", 32'(load_conn), 32'd0);
        chk("rst_addr", address, 32'd0);
        tick();
        clear_logs();
        do_start(1);
        agent_state = 4'b0110;
        full_cfg(32'h300);
        tick(); tick(); tick(); tick();
        chk("rerun_addr0", (seed_addr_log.size() > 0) ? seed_addr_log[0] : 32'hX, 32'd0);
        chk_list("rerun_counts", cnt_log, '{32'd2});

        // start during RUN is ignored.
        clear_logs();
        do_start(5);
        full_cfg(32'h400);
        agent_state = 4'b0000; tick();
        agent_state = 4'b1111; tick();
        agent_state = 4'b0110; start = 1; run_steps = 32'd9; tick(); start = 0;
        agent_state = 4'b1000; tick();
        agent_state = 4'b1110; tick();
        tick(); tick(); tick();
        chk_list("run5_steps", step_log, '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4});
        chk_list("run5_counts", cnt_log, '{32'd0, 32'd4, 32'd2, 32'd1, 32'd3});
        chk("run5_done", 32'(done_cnt), 32'd1);
        chk("run5_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sim_sequencer.md
SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 SHALL have parameter NUM_AGENTS, default 100, meaning the number of agents in the array (1..65535).
REQ-002 SHALL have derived localparam WORDS = ceil(NUM_AGENTS/32), meaning the number of 32-bit connectivity words per agent.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a configure-and-run sequence.
REQ-006 SHALL have port run_steps, input, 32, the number of simulation steps, sampled when start is accepted.
REQ-007 SHALL have port cfg_valid, input, 1, configuration word valid.
REQ-008 SHALL have port cfg_ready, output, 1, configuration word accepted.
REQ-009 SHALL have port cfg_data, input, 32, the configuration word.
REQ-010 SHALL have port address, output, 32, the target agent index.
REQ-011 SHALL have port seed_value, output, 32, the PRBS seed.
REQ-012 SHALL have port load_seed, output, 1, a seed load strobe.
REQ-013 SHALL have port init_state, output, 1, the initial agent state.
REQ-014 SHALL have port load_state, output, 1, a state load strobe.
REQ-015 SHALL have port load_conn, output, NUM_AGENTS, a one-hot per-agent connectivity load strobe.
REQ-016 SHALL have port conn_value, output, 32, the connectivity word.
REQ-017 SHALL have port agent_state, input, NUM_AGENTS, the current state of every agent (1 = INF).
REQ-018 SHALL have port stat_valid, output, 1, per-step statistic valid.
REQ-019 SHALL have port stat_step, output, 32, the step index.
REQ-020 SHALL have port stat_count, output, 16, the number of infected agents.
REQ-021 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-022 The FSM SHALL have states IDLE, SEED, STATE, CONN, RUN and FIN.
REQ-023 In IDLE, start=1 SHALL latch run_steps, clear the agent and word counters, and enter SEED; start SHALL be ignored in all other states.
REQ-024 cfg_ready SHALL be 1 exactly in SEED, STATE and CONN; a word is accepted when cfg_valid&cfg_ready.
REQ-025 SEED: each accepted word SHALL produce, on the next cycle only, load_seed=1, seed_value=cfg_data, and address=the agent counter; the agent counter SHALL increment, and after NUM_AGENTS words it SHALL clear and the FSM SHALL go to STATE.
REQ-026 STATE: each accepted word SHALL produce, on the next cycle only, load_state=1, init_state=cfg_data[0], and address=the agent counter; cfg_data[31:1] SHALL be ignored, and after NUM_AGENTS words the FSM SHALL go to CONN.
REQ-027 CONN: words SHALL arrive agent-major (agent 0 words 0..WORDS-1, then agent 1, ...); each accepted word SHALL produce, on the next cycle only, load_conn[agent]=1 (one-hot) and conn_value=cfg_data.
REQ-028 CONN: the word counter SHALL wrap at WORDS and increment the agent counter; after NUM_AGENTS*WORDS words the FSM SHALL enter RUN with the step counter at 0.
REQ-029 When NUM_AGENTS is not a multiple of 32, the upper bits of each agent's last word SHALL be passed through unmodified.
REQ-030 No load strobe SHALL assert without a preceding accepted word; during a cfg_valid gap all strobes SHALL be 0 and address, seed_value and conn_value SHALL hold.
REQ-031 RUN: each cycle SHALL register stat_valid=1, stat_count=popcount(agent_state), and stat_step=the step counter, then increment the step counter.
REQ-032 RUN SHALL exit to FIN after run_steps statistics have been emitted; run_steps=0 SHALL go from CONN directly to FIN with no stat_valid.
REQ-033 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 A strobe for the final word of a phase SHALL still be emitted on the cycle after the phase transition.

Reset
REQ-036 rst=1 SHALL, at the next clk edge and in any state (including mid-phase), force IDLE and clear all counters.
REQ-037 rst SHALL drive cfg_ready, load_seed, load_state, load_conn, stat_valid, done and busy to 0.
REQ-038 rst SHALL drive address, seed_value, conn_value, stat_step and stat_count to 0.
REQ-039 rst SHALL drive init_state to 0.

Verification (NUM_AGENTS=4, WORDS=1)
REQ-040 Seed phase: start, run_steps=2, seed words 0x11..0x14 streamed back-to-back -> load_seed pulses on 4 consecutive cycles with address 0..3 and seed_value 0x11..0x14.
REQ-041 Full sequence with gaps: state words 1,0,0,0 and conn words 0x2,0x5,0xA,0x4 with cfg_valid toggling -> exactly one strobe per word, load_conn = 0001, 0010, 0100, 1000, no strobe during gaps.
REQ-042 Run phase: agent_state driven 4'b1011 then 4'b0001 during RUN -> stat_count 3 (step 0), 1 (step 1); done pulses one cycle later; then IDLE and busy=0.
REQ-043 run_steps=0 -> no stat_valid; done follows the last conn strobe.
REQ-044 rst asserted mid-CONN after 2 words -> the next cycle shows IDLE with all strobes 0; a new start reruns from SEED with address 0.
REQ-045 start pulsed during RUN -> ignored, with the step count unaffected.
